sht30_sequencer: RTL
====================

Name: sht30_sequencer

Overview:
Measurement scheduler for the SHT30 humidity/temperature sensor. It sits between the application and the bit-level I2C controller in the same clk_50K domain. Per measurement it issues a write transaction carrying the single-shot command, waits out the conversion time, then issues a read transaction for 6 bytes. It CRC-checks both words and publishes raw temperature and humidity. Runs single-shot on trigger or periodically when enabled, and recovers a hung I2C controller via timeout and controller reset.

Parameters:
I2C_ADDR, 7'h44, sensor 7-bit address (write byte 0x88, read byte 0x89)
CMD, 16'h2400, measurement command (high repeatability, no clock stretching), MSB sent first
MEAS_WAIT, 16'd800, cycles from command STOP to read START (16 ms at 50 kHz)
PERIOD, 16'd50000, cycles between measurement starts when enable=1 (1 s)
TIMEOUT, 16'd2000, max cycles per I2C transaction from start pulse to return to IDLE

Ports:
clk_50K  in  1  clock, 50 kHz
rstn  in  1  synchronous, active-low reset
enable  in  1  level; periodic measurement mode
trigger  in  1  one-cycle pulse; single measurement, ignored while busy
i2c_state  in  3  controller state (IDLE=0, START=1, WRITE=2, WAIT_ACK=3, READ=4, SEND_ACK=5, STOP=6)
ack_returned  in  1  controller ACK flag (observed only, not used for sequencing)
rdata  in  48  controller read shift register, valid after read transaction ends
i2c_start  out  1  one-cycle start request to controller
i2c_wdata  out  8  current byte to transmit
i2c_last_wdata  out  1  current byte is the last write byte
i2c_expect_response  out  1  transaction reads 48 bits after last write byte
i2c_rstn  out  1  synchronous active-low reset to controller, AND of rstn and recovery pulse
busy  out  1  high in every state except IDLE
temp_raw  out  16  last good temperature word
hum_raw  out  16  last good humidity word
data_valid  out  1  one-cycle pulse when temp_raw and hum_raw update
crc_error  out  1  sticky; set on CRC mismatch, cleared by next data_valid
timeout_error  out  1  sticky; set on transaction timeout, cleared by next data_valid

Behaviour:
- Reset: state IDLE. All outputs 0 except i2c_rstn=rstn and i2c_wdata=0x00. Counters 0. A reset mid-transaction abandons it; the controller is reset by the same rstn.
- States: IDLE, CMD_START, CMD_XFER, MEAS_WAIT, RD_START, RD_XFER, CRC_CHECK, PERIOD_WAIT, RECOVER.
- IDLE -> CMD_START on trigger | enable.
- CMD_START / RD_START: assert i2c_start for exactly one cycle when i2c_state==IDLE, then go to the matching _XFER state. Byte index is reset to 0 and the timeout counter is cleared.
- Byte sequencing:
  - Byte index increments when the registered previous i2c_state==WRITE and the current i2c_state==WAIT_ACK.
  - Command bytes: 0x88, CMD[15:8], CMD[7:0]; i2c_last_wdata=1 only at index 2; i2c_expect_response=0.
  - Read transaction: byte 0x89 only; i2c_last_wdata=1 and i2c_expect_response=1 throughout RD_START/RD_XFER.
  - i2c_wdata and i2c_last_wdata are combinational from state and index.
- Transaction end: previous i2c_state==STOP and current==IDLE.
  - CMD_XFER -> MEAS_WAIT.
  - RD_XFER -> CRC_CHECK; rdata is latched the same cycle.
- Timeout: in either _XFER state, the counter reaching TIMEOUT-1 -> RECOVER; timeout_error<=1.
- RECOVER: i2c_rstn low for exactly 2 cycles, then PERIOD_WAIT.
- MEAS_WAIT: count MEAS_WAIT cycles, then RD_START.
- CRC_CHECK:
  - Serial CRC-8, poly 0x31, init 0xFF, MSB-first, no final XOR.
  - Computed over latched[47:32] and latched[23:8] in parallel, 1 bit/cycle, 16 cycles.
  - 17th cycle compares against latched[31:24] and latched[7:0].
  - Both match: temp_raw<=latched[47:32], hum_raw<=latched[23:8], data_valid pulse, both sticky errors cleared.
  - Either mismatch: crc_error<=1, data outputs unchanged.
  - Then PERIOD_WAIT.
- PERIOD_WAIT:
  - Period counter counts from the CMD_START entry cycle.
  - enable=0: go to IDLE immediately.
  - enable=1: wait until the counter reaches PERIOD-1, then CMD_START. If already exceeded, go next cycle.
- trigger during busy is dropped. enable deasserted mid-measurement: the current measurement completes, then IDLE.

Test Plan:
- trigger, model ACKs, returns T=0xBEEF crc 0x92, RH=0xBEEF crc 0x92 -> bytes 0x88,0x24,0x00 with last only on 3rd; ≥800 cycles gap; 0x89 with expect_response; data_valid one pulse; temp_raw=hum_raw=0xBEEF; errors 0.
- Same but RH crc 0x93 -> crc_error=1, no data_valid, temp_raw/hum_raw keep prior values; next good read clears crc_error.
- Model never ACKs (controller stuck WAIT_ACK) -> timeout_error=1 exactly TIMEOUT cycles after i2c_start; i2c_rstn low 2 cycles; returns IDLE.
- enable=1 with PERIOD=3000 -> consecutive i2c_start pulses for the command write exactly 3000 cycles apart; deassert enable -> current measurement finishes, busy falls, no further starts.
- rstn low during RD_XFER -> next cycle all outputs at reset values; trigger during busy produces no extra transaction.

Source files
------------

// File: rtl/sht30_sequencer.sv
// SHT30 measurement scheduler sitting in front of a bit-level I2C controller.
// Issues the single-shot command write, waits out the conversion, reads the
// 6-byte result, CRC-checks both words and publishes raw temperature/humidity.
// Runs single-shot on trigger or periodically while enable is high, and
// recovers a hung controller with a timeout plus a short controller reset.
//
// Ports:
//   clk_50K, rstn        clock and synchronous active-low reset
//   enable, trigger      periodic mode level / single-shot request pulse
//   i2c_state            controller state (IDLE=0 ... STOP=6)
//   ack_returned         controller ACK flag (observed only)
//   rdata                controller read shift register
//   i2c_start            one-cycle transaction start request
//   i2c_wdata            byte to transmit (combinational)
//   i2c_last_wdata       current byte is the last write byte (combinational)
//   i2c_expect_response  transaction reads 48 bits after the last write byte
//   i2c_rstn             controller reset: rstn AND recovery pulse
//   busy                 high outside IDLE
//   temp_raw, hum_raw    last CRC-clean words
//   data_valid           one-cycle pulse when the words update
//   crc_error            sticky CRC mismatch flag, cleared by data_valid
//   timeout_error        sticky transaction timeout flag, cleared by data_valid
module sht30_sequencer #(
  parameter logic [6:0]  I2C_ADDR  = 7'h44,
  parameter logic [15:0] CMD       = 16'h2400,
  parameter logic [15:0] MEAS_WAIT = 16'd800,
  parameter logic [15:0] PERIOD    = 16'd50000,
  parameter logic [15:0] TIMEOUT   = 16'd2000
) (
  input  logic        clk_50K,
  input  logic        rstn,
  input  logic        enable,
  input  logic        trigger,
  input  logic [2:0]  i2c_state,
  input  logic        ack_returned,
  input  logic [47:0] rdata,
  output logic        i2c_start,
  output logic [7:0]  i2c_wdata,
  output logic        i2c_last_wdata,
  output logic        i2c_expect_response,
  output logic        i2c_rstn,
  output logic        busy,
  output logic [15:0] temp_raw,
  output logic [15:0] hum_raw,
  output logic        data_valid,
  output logic        crc_error,
  output logic        timeout_error
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BIT_W  = 5;
  localparam int unsigned CRC_W  = 8;
  localparam int unsigned WORD_W = 16;

  localparam logic [2:0] I2C_IDLE     = 3'd0;
  localparam logic [2:0] I2C_WRITE    = 3'd2;
  localparam logic [2:0] I2C_WAIT_ACK = 3'd3;
  localparam logic [2:0] I2C_STOP     = 3'd6;

  localparam logic [BIT_W-1:0] CRC_BITS = BIT_W'(16);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD_START,
    S_CMD_XFER,
    S_MEAS_WAIT,
    S_RD_START,
    S_RD_XFER,
    S_CRC_CHECK,
    S_PERIOD_WAIT,
    S_RECOVER
  } state_t;

  state_t              state, next_state;
  logic [2:0]          prev_i2c;
  logic [1:0]          byte_idx;
  logic [CNT_W-1:0]    tout_cnt;
  logic [CNT_W-1:0]    wait_cnt;
  logic [CNT_W-1:0]    period_cnt;
  logic                rec_cnt;
  logic                rec_low;
  logic [BIT_W-1:0]    bit_cnt;
  logic [WORD_W-1:0]   sh_t, sh_h;
  logic [CRC_W-1:0]    crc_t, crc_h;
  logic [CRC_W-1:0]    lat_crc_t, lat_crc_h;

  logic start_c, txn_end_c, in_xfer_c, timeout_c, crc_ok_c, crc_done_c;

  // ACK is informational only; sequencing relies on controller state.
  logic unused_ack;
  assign unused_ack = ack_returned;

  assign i2c_rstn = rstn & ~rec_low;

  // One step of the MSB-first CRC-8 (poly 0x31) over a single input bit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    crc8_step = {crc[6:0], 1'b0} ^ (((crc[7] ^ din) == 1'b1) ? 8'h31 : 8'h00);
  endfunction

  // State register.
  always_ff @(posedge clk_50K) begin
    if (!rstn) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state and per-cycle strobes.
  always_comb begin
    next_state = state;
    start_c    = 1'b0;
    txn_end_c  = (prev_i2c == I2C_STOP) && (i2c_state == I2C_IDLE);
    in_xfer_c  = (state == S_CMD_XFER) || (state == S_RD_XFER);
    timeout_c  = 1'b0;
    crc_done_c = (state == S_CRC_CHECK) && (bit_cnt == CRC_BITS);
    crc_ok_c   = (crc_t == lat_crc_t) && (crc_h == lat_crc_h);
    case (state)
      S_IDLE:
        if (trigger || enable) next_state = S_CMD_START;
      S_CMD_START:
        if (i2c_state == I2C_IDLE) begin
          start_c    = 1'b1;
          next_state = S_CMD_XFER;
        end
      S_CMD_XFER:
        if (txn_end_c) next_state = S_MEAS_WAIT;
        else if (tout_cnt == TIMEOUT - 16'd1) begin
          timeout_c  = 1'b1;
          next_state = S_RECOVER;
        end
      S_MEAS_WAIT:
        if (wait_cnt == MEAS_WAIT - 16'd1) next_state = S_RD_START;
      S_RD_START:
        if (i2c_state == I2C_IDLE) begin
          start_c    = 1'b1;
          next_state = S_RD_XFER;
        end
      S_RD_XFER:
        if (txn_end_c) next_state = S_CRC_CHECK;
        else if (tout_cnt == TIMEOUT - 16'd1) begin
          timeout_c  = 1'b1;
          next_state = S_RECOVER;
        end
      S_CRC_CHECK:
        if (crc_done_c) next_state = S_PERIOD_WAIT;
      S_PERIOD_WAIT:
        if (!enable) next_state = S_IDLE;
        else if (period_cnt >= PERIOD - 16'd1) next_state = S_CMD_START;
      S_RECOVER:
        if (rec_cnt) next_state = S_PERIOD_WAIT;
      default:
        next_state = S_IDLE;
    endcase
  end

  // Byte presented to the controller, selected by transaction and byte index.
  always_comb begin
    i2c_wdata      = 8'h00;
    i2c_last_wdata = 1'b0;
    case (state)
      S_CMD_START, S_CMD_XFER:
        case (byte_idx)
          2'd0: i2c_wdata = {I2C_ADDR, 1'b0};
          2'd1: i2c_wdata = CMD[15:8];
          2'd2: begin
            i2c_wdata      = CMD[7:0];
            i2c_last_wdata = 1'b1;
          end
          default: i2c_wdata = 8'h00;
        endcase
      S_RD_START, S_RD_XFER: begin
        i2c_wdata      = {I2C_ADDR, 1'b1};
        i2c_last_wdata = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: counters, controller handshake, CRC engine and result registers.
  always_ff @(posedge clk_50K) begin
    if (!rstn) begin
      prev_i2c            <= I2C_IDLE;
      byte_idx            <= 2'd0;
      tout_cnt            <= '0;
      wait_cnt            <= '0;
      period_cnt          <= '0;
      rec_cnt             <= 1'b0;
      rec_low             <= 1'b0;
      bit_cnt             <= '0;
      sh_t                <= '0;
      sh_h                <= '0;
      crc_t               <= '0;
      crc_h               <= '0;
      lat_crc_t           <= '0;
      lat_crc_h           <= '0;
      i2c_start           <= 1'b0;
      i2c_expect_response <= 1'b0;
      busy                <= 1'b0;
      temp_raw            <= '0;
      hum_raw             <= '0;
      data_valid          <= 1'b0;
      crc_error           <= 1'b0;
      timeout_error       <= 1'b0;
    end else begin
      prev_i2c            <= i2c_state;
      i2c_start           <= start_c;
      busy                <= (next_state != S_IDLE);
      i2c_expect_response <= (next_state == S_RD_START) || (next_state == S_RD_XFER);
      rec_low             <= (next_state == S_RECOVER);
      rec_cnt             <= (state == S_RECOVER) ? ~rec_cnt : 1'b0;
      data_valid          <= 1'b0;

      // A byte is done when the controller moves from WRITE into WAIT_ACK.
      if ((state == S_CMD_START) || (state == S_RD_START))
        byte_idx <= 2'd0;
      else if ((prev_i2c == I2C_WRITE) && (i2c_state == I2C_WAIT_ACK) && (byte_idx != 2'd3))
        byte_idx <= byte_idx + 2'd1;

      if ((state == S_CMD_START) || (state == S_RD_START)) tout_cnt <= '0;
      else if (in_xfer_c)                                   tout_cnt <= tout_cnt + 16'd1;

      if (state == S_MEAS_WAIT) wait_cnt <= wait_cnt + 16'd1;
      else                      wait_cnt <= '0;

      // Period is measured from the first cycle of each CMD_START; saturates.
      if ((next_state == S_CMD_START) && (state != S_CMD_START)) period_cnt <= '0;
      else if (period_cnt != 16'hFFFF)                            period_cnt <= period_cnt + 16'd1;

      if (timeout_c) timeout_error <= 1'b1;

      // Latch the read result; the words rotate so they are intact after 16 steps.
      if ((state == S_RD_XFER) && (next_state == S_CRC_CHECK)) begin
        sh_t      <= rdata[47:32];
        lat_crc_t <= rdata[31:24];
        sh_h      <= rdata[23:8];
        lat_crc_h <= rdata[7:0];
        crc_t     <= 8'hFF;
        crc_h     <= 8'hFF;
        bit_cnt   <= '0;
      end else if ((state == S_CRC_CHECK) && !crc_done_c) begin
        crc_t   <= crc8_step(crc_t, sh_t[15]);
        crc_h   <= crc8_step(crc_h, sh_h[15]);
        sh_t    <= {sh_t[14:0], sh_t[15]};
        sh_h    <= {sh_h[14:0], sh_h[15]};
        bit_cnt <= bit_cnt + 5'd1;
      end

      if (crc_done_c) begin
        if (crc_ok_c) begin
          temp_raw      <= sh_t;
          hum_raw       <= sh_h;
          data_valid    <= 1'b1;
          crc_error     <= 1'b0;
          timeout_error <= 1'b0;
        end else begin
          crc_error <= 1'b1;
        end
      end
    end
  end

endmodule
